// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART types, constants and baud divisor helper
// Rev 1.0
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_e;

  // Rounded clocks-per-tick divisor.
  function automatic int uart_div(input int clk_freq, input int baud, input int oversample);
    return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// uart_baud_tick : free-running divider, 1-cycle tick every DIV clocks,
//                  synchronous clear to re-phase against a line event
// Rev 1.0
// ============================================================================
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int c_CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

  logic [c_CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// uart_rx_byte : 16x oversampled UART receiver with valid/ready byte output,
//                framing/overrun pulses. Define UART_PARITY_EN for 8E1.
// Rev 1.0
// ============================================================================
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                   clk_50m,
  input  logic                   sw_rst_n,
  input  logic                   uart_rx,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   parity_err
);

  localparam int c_DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int c_TW  = $clog2(OVERSAMPLE);
  localparam int c_BW  = $clog2(UART_DATA_W);
  localparam logic [c_TW-1:0] c_MID   = c_TW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_TW-1:0] c_TLAST = c_TW'(OVERSAMPLE - 1);
  localparam logic [c_BW-1:0] c_BLAST = c_BW'(UART_DATA_W - 1);

  localparam logic [2:0] c_S_IDLE      = 3'(ST_IDLE);
  localparam logic [2:0] c_S_START     = 3'(ST_START);
  localparam logic [2:0] c_S_DATA      = 3'(ST_DATA);
`ifdef UART_PARITY_EN
  localparam logic [2:0] c_S_PARITY    = 3'(ST_PARITY);
`endif
  localparam logic [2:0] c_S_STOP      = 3'(ST_STOP);
  localparam logic [2:0] c_S_WAIT_IDLE = 3'(ST_WAIT_IDLE);

  logic                   r_sync1, r_sync2, r_line_prev;
  logic                   w_line, w_fall, w_start, w_tick, w_mid;
  logic [c_TW-1:0]        r_tick_cnt;
  logic [2:0]             r_state;
  logic [c_BW-1:0]        r_bit_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic                   r_deliver;
  logic                   r_frame_err;
  logic [UART_DATA_W-1:0] r_rx_data;
  logic                   r_rx_valid;
  logic                   r_overrun;

  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_line_prev <= 1'b1;
    end else begin
      r_sync1     <= uart_rx;
      r_sync2     <= r_sync1;
      r_line_prev <= r_sync2;
    end
  end

  assign w_line  = r_sync2;
  assign w_fall  = r_line_prev & ~r_sync2;
  assign w_start = (r_state == c_S_IDLE) & w_fall;
  assign w_mid   = w_tick & (r_tick_cnt == c_MID);

  // Cleared with the start edge so every mid sample lands at a fixed phase.
  uart_baud_tick #(
    .DIV(c_DIV)
  ) u_baud_tick (
    .clk     (clk_50m),
    .rst_n   (sw_rst_n),
    .i_clear (w_start),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_start) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= (r_tick_cnt == c_TLAST) ? '0 : r_tick_cnt + 1'b1;
    end
  end

`ifdef UART_PARITY_EN
  logic r_par_bad;
`endif

  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      r_state     <= c_S_IDLE;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_deliver   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      r_par_bad   <= 1'b0;
`endif
    end else begin
      r_deliver   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          if (w_fall) r_state <= c_S_START;
        end
        c_S_START: begin
          if (w_mid) begin
            if (w_line) begin
              r_state <= c_S_IDLE;
            end else begin
              r_state   <= c_S_DATA;
              r_bit_idx <= '0;
            end
          end
        end
        c_S_DATA: begin
          if (w_mid) begin
            r_shift   <= {w_line, r_shift[UART_DATA_W-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == c_BLAST) begin
`ifdef UART_PARITY_EN
              r_state <= c_S_PARITY;
`else
              r_state <= c_S_STOP;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        c_S_PARITY: begin
          if (w_mid) begin
            r_par_bad <= w_line ^ (^r_shift);
            r_state   <= c_S_STOP;
          end
        end
`endif
        c_S_STOP: begin
          if (w_mid) begin
            if (w_line) begin
              r_deliver <= 1'b1;
              r_state   <= c_S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= c_S_WAIT_IDLE;
            end
          end
        end
        c_S_WAIT_IDLE: begin
          if (w_line) r_state <= c_S_IDLE;
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  // A full holder may still take a new byte when it is drained in the same cycle.
  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_deliver) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= r_deliver & r_par_bad;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_rx_byte : directed frames against an event-scheduled holder model
// Rev 1.0
// ============================================================================
module tb_uart_rx_byte;
  import uart_pkg::*;

  localparam int c_DIV  = (50_000_000 + 115200 * 16 / 2) / (115200 * 16);
  localparam int c_BIT  = c_DIV * 16;
  localparam int c_PIPE = 3;  // two sync flops plus the edge register
`ifdef UART_PARITY_EN
  localparam int c_NB = 11;
`else
  localparam int c_NB = 10;
`endif
  // Clocks from driving the start bit to the stop-bit mid sample.
  localparam int c_STOP_MID = c_BIT * (c_NB - 1) + c_BIT / 2 + c_PIPE;

  logic                   clk_50m  = 1'b0;
  logic                   sw_rst_n = 1'b0;
  logic                   uart_rx  = 1'b1;
  logic                   rx_ready = 1'b0;
  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_valid, frame_err, overrun, parity_err;

  uart_rx_byte dut (
    .clk_50m    (clk_50m),
    .sw_rst_n   (sw_rst_n),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct packed {
    int         cyc;
    logic [7:0] d;
    logic       pb;
  } dev_t;

  dev_t       dq[$];
  int         fq[$];
  logic [7:0] xfer_log[$];
  int         cyc = 0, total = 0, bad = 0;
  int         ovr_seen = 0, ferr_seen = 0, perr_seen = 0, rise_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Model: scheduled deliveries / framing events applied to a one-entry holder.
  initial begin
    logic       m_valid, e_ferr, e_ovr, e_par, prev_v;
    logic [7:0] m_data, prev_d;
    dev_t       ev;
    m_valid = 1'b0; m_data = 8'h00; prev_v = 1'b0; prev_d = 8'h00;
    forever begin
      @(posedge clk_50m);
      #1;
      cyc++;
      if (sw_rst_n && prev_v && rx_ready) xfer_log.push_back(prev_d);
      if (!prev_v && rx_valid) rise_cyc = cyc;
      prev_v = rx_valid;
      prev_d = rx_data;
      if (frame_err)  ferr_seen++;
      if (overrun)    ovr_seen++;
      if (parity_err) perr_seen++;

      e_ferr = 1'b0; e_ovr = 1'b0; e_par = 1'b0;
      if (!sw_rst_n) begin
        m_valid = 1'b0;
        m_data  = 8'h00;
      end else begin
        if (fq.size() > 0 && fq[0] == cyc) begin
          e_ferr = 1'b1;
          void'(fq.pop_front());
        end
        if (dq.size() > 0 && dq[0].cyc == cyc) begin
          ev    = dq.pop_front();
          e_par = ev.pb;
          if (!m_valid || rx_ready) begin
            m_data  = ev.d;
            m_valid = 1'b1;
          end else begin
            e_ovr = 1'b1;
          end
        end else if (m_valid && rx_ready) begin
          m_valid = 1'b0;
        end
      end
      chk("rx_valid", rx_valid, m_valid);
      chk("rx_data", rx_data, m_data);
      chk("frame_err", frame_err, e_ferr);
      chk("overrun", overrun, e_ovr);
      chk("parity_err", parity_err, e_par);
    end
  end

  // Drives one frame starting at the current negedge; optional reset abort mid data bit.
  task automatic send(input logic [7:0] d, input bit good_stop, input bit flip_par,
                      input int abort_bit, output int n);
    logic [11:0] fr;
    dev_t        e;
    fr       = '1;
    fr[0]    = 1'b0;
    fr[8:1]  = d;
`ifdef UART_PARITY_EN
    fr[9]    = (^d) ^ flip_par;
    fr[10]   = good_stop;
    e.pb     = ^fr[9:1];
`else
    fr[9]    = good_stop;
    e.pb     = 1'b0;
    if (flip_par) $display("note: parity flip has no effect in the 8N1 build");
`endif
    n = cyc;
    if (abort_bit < 0) begin
      if (good_stop) begin
        e.cyc = n + c_STOP_MID + 1;
        e.d   = d;
        dq.push_back(e);
      end else begin
        fq.push_back(n + c_STOP_MID);
      end
    end
    for (int i = 0; i < c_NB; i++) begin
      uart_rx = fr[i];
      if (abort_bit >= 0 && i == abort_bit + 1) begin
        repeat (c_BIT / 2) @(negedge clk_50m);
        sw_rst_n = 1'b0;
        uart_rx  = 1'b1;
        #1;
        chk("rst rx_valid", rx_valid, 1'b0);
        chk("rst rx_data", rx_data, 8'h00);
        chk("rst frame_err", frame_err, 1'b0);
        chk("rst overrun", overrun, 1'b0);
        chk("rst parity_err", parity_err, 1'b0);
        repeat (4) @(negedge clk_50m);
        sw_rst_n = 1'b1;
        return;
      end
      repeat (c_BIT) @(negedge clk_50m);
    end
    if (!good_stop) begin
      repeat (2000) @(negedge clk_50m);
      uart_rx = 1'b1;
    end
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    @(negedge clk_50m);
    rx_ready = 1'b0;
  endtask

  initial begin
    int n, k, c0;
    repeat (5) @(negedge clk_50m);
    sw_rst_n = 1'b1;
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset rx_data", rx_data, 8'h00);
    chk("reset frame_err", frame_err, 1'b0);
    chk("reset overrun", overrun, 1'b0);
    repeat (20) @(negedge clk_50m);

    // Single byte, latency and drain
    send(8'h55, 1'b1, 1'b0, -1, n);
    chk("t1 data", rx_data, 8'h55);
    chk("t1 valid", rx_valid, 1'b1);
    chk("t1 latency", (rise_cyc - n >= c_BIT * (c_NB - 1) + c_BIT / 2) &&
                      (rise_cyc - n <= c_BIT * (c_NB - 1) + c_BIT / 2 + 4), 1'b1);
    drain();
    chk("t1 drained", rx_valid, 1'b0);
    repeat (c_BIT) @(negedge clk_50m);

    // Back-to-back with consumer always ready
    k = xfer_log.size(); c0 = ovr_seen;
    rx_ready = 1'b1;
    send(8'hA3, 1'b1, 1'b0, -1, n);
    send(8'h0F, 1'b1, 1'b0, -1, n);
    rx_ready = 1'b0;
    chk("t2 xfer count", xfer_log.size() - k, 2);
    chk("t2 first", xfer_log[k], 8'hA3);
    chk("t2 second", xfer_log[k + 1], 8'h0F);
    chk("t2 no overrun", ovr_seen - c0, 0);
    chk("t2 no frame_err", ferr_seen, 0);
    repeat (c_BIT) @(negedge clk_50m);

    // Overrun: second byte dropped
    c0 = ovr_seen;
    send(8'h12, 1'b1, 1'b0, -1, n);
    send(8'h34, 1'b1, 1'b0, -1, n);
    chk("t3 held data", rx_data, 8'h12);
    chk("t3 overrun once", ovr_seen - c0, 1);
    drain();
    chk("t3 xfer old byte", xfer_log[xfer_log.size() - 1], 8'h12);
    chk("t3 drained", rx_valid, 1'b0);
    repeat (c_BIT) @(negedge clk_50m);

    // Bad stop bit, line stuck low, then recovery
    c0 = ferr_seen;
    send(8'h7E, 1'b0, 1'b0, -1, n);
    chk("t4 frame_err once", ferr_seen - c0, 1);
    chk("t4 no valid", rx_valid, 1'b0);
    repeat (c_BIT) @(negedge clk_50m);
    send(8'h81, 1'b1, 1'b0, -1, n);
    chk("t4 recovered data", rx_data, 8'h81);
    chk("t4 recovered valid", rx_valid, 1'b1);

    // Short low glitch must be ignored
    c0 = ferr_seen + ovr_seen;
    uart_rx = 1'b0;
    repeat (130) @(negedge clk_50m);
    uart_rx = 1'b1;
    repeat (11 * c_BIT) @(negedge clk_50m);
    chk("t5 glitch no events", ferr_seen + ovr_seen - c0, 0);
    chk("t5 holder kept", rx_data, 8'h81);

    // Reset mid-frame at data bit 4, then a clean frame
    send(8'h99, 1'b1, 1'b0, 4, n);
    repeat (2 * c_BIT) @(negedge clk_50m);
    send(8'hC6, 1'b1, 1'b0, -1, n);
    chk("t6 data", rx_data, 8'hC6);
    chk("t6 valid", rx_valid, 1'b1);
    drain();
    repeat (c_BIT) @(negedge clk_50m);

`ifdef UART_PARITY_EN
    c0 = perr_seen;
    send(8'h07, 1'b1, 1'b0, -1, n);
    chk("t7 good parity data", rx_data, 8'h07);
    chk("t7 good parity no err", perr_seen - c0, 0);
    drain();
    repeat (c_BIT) @(negedge clk_50m);
    send(8'h07, 1'b1, 1'b1, -1, n);
    chk("t7 bad parity valid", rx_valid, 1'b1);
    chk("t7 bad parity data", rx_data, 8'h07);
    chk("t7 bad parity pulse", perr_seen - c0, 1);
    drain();
`else
    chk("no parity pulses", perr_seen, 0);
`endif

    repeat (100) @(negedge clk_50m);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(20 * 150_000);
    bad++;
    $display("FAIL watchdog: cycle budget exhausted at cyc %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
